wimax_interleaver: RTL and testbench
====================================

# wimax_interleaver

Two-buffer (ping-pong) block interleaver for the WiMAX OFDM PHY transmit chain, placed between the convolutional encoder and the modulator/mapper. It accepts a serial bitstream in 192-bit coded blocks and applies the IEEE 802.16 two-step permutation for QPSK (Ncbps=192, Ncpc=2, s=1, d=16). It emits each block serially in permuted order. While one buffer is being drained, the other buffer fills, so throughput is continuous at one bit per clock.

## Interface
- NCBPS, 192: coded bits per block, fixed for this build.
- D, 16: permutation column count; NCBPS/D = 12 rows.
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous reset, active-high despite the name. All state is cleared while rstn=1.
- Valid_in  input  1  upstream bit valid.
- Data_in  input  1  upstream serial coded bit.
- Ready_in  input  1  downstream ready to accept Data_out.
- Ready_out  output  1  block can accept Data_in this cycle.
- Valid_out  output  1  Data_out holds a valid interleaved bit.
- Data_out  output  1  serial interleaved bit.

## Operation
- Two 192-bit buffers, A and B, each with a full flag. There is one write-buffer select and one read-buffer select, and both start at A.
- Input transfer occurs when Valid_in && Ready_out. Input bit k (k = 0..191, counted from the first accepted bit of the block) is written to buffer position m = 12*(k mod 16) + floor(k/16).
  - The second permutation is the identity for s=1.
  - Implement the write address with a column counter (0..15) and a row counter (0..11); no multiplier is needed.
- After bit k=191 is written, the write buffer's full flag sets, the write select toggles, and k returns to 0.
- Output transfer occurs when Valid_out && Ready_in. Positions 0..191 of the read buffer are emitted in ascending order.
- After position 191 is transferred, the read buffer's full flag clears, the read select toggles, and the read pointer returns to 0.
- Ready_out = !full[write select].
- Valid_out = full[read select].
- Data_out = read buffer[read pointer]. It is a mux of registered state, and is 0 when Valid_out=0.
- Permutation check: output position j maps to input bit k = 16*(j mod 12) + floor(j/12).

## Timing
- Reset values:
  - Valid_out=0, Data_out=0, Ready_out=1.
  - Both full flags 0, all pointers 0, both selects at A, buffer contents 0.
- Latency: if the 192nd input bit is accepted at edge N, Valid_out=1 and output position 0 is on Data_out right after edge N. The block streams one bit per cycle while Ready_in=1.
- Gaps in Valid_in stall the write counter. Ready_in=0 holds Data_out and the read pointer.
- Both buffers full: Ready_out=0 and input is stalled.
- Simultaneous events on the same edge:
  - A read-buffer release and a write-buffer completion on the same edge are both honoured.
  - The freed buffer shows Ready_out=1 on the next cycle.
- A reset mid-block discards all partial and full blocks immediately, with no output.
- Data_in is ignored whenever Ready_out=0 or Valid_in=0.

## Configuration
- INTERLEAVER_BYPASS_EN defined:
  - Adds input port `bypass` (1 bit), which is sampled at bit k=0 of each block and stored per buffer.
  - A block with bypass=1 is written in natural order (m=k).
  - All handshake behaviour and latency are unchanged.
- INTERLEAVER_BYPASS_EN undefined: the port is absent and the permutation is always applied.

## Test plan
- Reset: assert rstn for 1 cycle, then release. Required response: Valid_out=0, Data_out=0, Ready_out=1.
- Single block:
  - Stimulus: feed 0x2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA MSB-first with Valid_in=1 continuously, then Ready_in=1.
  - Required response: Data_out MSB-first equals 0x4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E. Valid_out rises the cycle after the 192nd input bit.
- Ping-pong:
  - Stimulus: send the same block three times back-to-back with Ready_in=1.
  - Required response: Ready_out stays 1 throughout. Output is three identical copies of the expected vector, 576 correct bits, 0 errors.
- Backpressure:
  - Stimulus: hold Ready_in=0 and send two blocks.
  - Required response: Ready_out drops to 0 after the 384th accepted bit. A third block stalls.
  - Then raise Ready_in: Ready_out returns to 1 after 192 outputs.
- Single-one walk: input block with only bit k=17 set. Required response: only output position 12*1+1 = 13 is 1.
- Reset mid-block: assert rstn after 100 input bits. Required response: no Valid_out occurs. A following full block interleaves correctly.

Source files
------------

// File: rtl/wimax_interleaver.sv
// Ping-pong block interleaver for WiMAX QPSK (Ncbps=192, d=16): serial bits in, permuted bits out.
// Define INTERLEAVER_BYPASS_EN to add a per-block `bypass` input that stores a block in natural order.
module wimax_interleaver (
  input  logic clk,
  input  logic rstn,
`ifdef INTERLEAVER_BYPASS_EN
  input  logic bypass,
`endif
  input  logic Valid_in,
  input  logic Data_in,
  input  logic Ready_in,
  output logic Ready_out,
  output logic Valid_out,
  output logic Data_out
);
  localparam int NCBPS = 192;
  localparam int D     = 16;
  localparam int ROWS  = NCBPS / D;
  localparam int AW    = 8;

  logic [NCBPS-1:0] buf_mem [2];
  logic [1:0]       full;
  logic             wr_sel;
  logic             rd_sel;
  logic [3:0]       col;
  logic [3:0]       row;
  logic [AW-1:0]    col_base;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_addr;
  logic             wr_fire;
  logic             rd_fire;
  logic             wr_last;
  logic             rd_last;
`ifdef INTERLEAVER_BYPASS_EN
  logic [1:0]       byp;
  logic             byp_now;
`endif

  assign wr_fire   = Valid_in && Ready_out;
  assign rd_fire   = Valid_out && Ready_in;
  assign wr_last   = (col == 4'(D - 1)) && (row == 4'(ROWS - 1));
  assign rd_last   = (rd_ptr == AW'(NCBPS - 1));
  assign Ready_out = !full[wr_sel];
  assign Valid_out = full[rd_sel];
  assign Data_out  = Valid_out && buf_mem[rd_sel][rd_ptr];

  // k = 16*row + col; col_base tracks 12*col so m = 12*col + row needs only an add.
  always_comb begin
    wr_addr = col_base + AW'(row);
`ifdef INTERLEAVER_BYPASS_EN
    byp_now = (col == 4'd0 && row == 4'd0) ? bypass : byp[wr_sel];
    if (byp_now) wr_addr = {row, col};
`endif
  end

  // NOTE: the buffers are cleared on reset because their reset contents are defined
  // behaviour here; a plain storage RAM would normally be left unreset.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else if (wr_fire) begin
      buf_mem[wr_sel][wr_addr] <= Data_in;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      col      <= '0;
      row      <= '0;
      col_base <= '0;
      wr_sel   <= 1'b0;
    end else if (wr_fire) begin
      if (col == 4'(D - 1)) begin
        col      <= '0;
        col_base <= '0;
        row      <= wr_last ? 4'd0 : row + 4'd1;
      end else begin
        col      <= col + 4'd1;
        col_base <= col_base + AW'(ROWS);
      end
      if (wr_last) wr_sel <= ~wr_sel;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      rd_ptr <= '0;
      rd_sel <= 1'b0;
    end else if (rd_fire) begin
      if (rd_last) begin
        rd_ptr <= '0;
        rd_sel <= ~rd_sel;
      end else begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // A completing write and a releasing read always target different buffers.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      full <= '0;
    end else begin
      if (wr_fire && wr_last) full[wr_sel] <= 1'b1;
      if (rd_fire && rd_last) full[rd_sel] <= 1'b0;
    end
  end

`ifdef INTERLEAVER_BYPASS_EN
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      byp <= '0;
    end else if (wr_fire && col == 4'd0 && row == 4'd0) begin
      byp[wr_sel] <= bypass;
    end
  end
`endif

endmodule

// File: tb/tb_wimax_interleaver.sv
// Self-checking bench for wimax_interleaver: vector table, ping-pong, backpressure,
// mid-block reset and randomized handshakes against a permutation-formula model.
module tb_wimax_interleaver;
  localparam int N = 192;

  logic clk = 1'b0;
  logic rstn;
  logic Valid_in, Data_in, Ready_in;
  logic Ready_out, Valid_out, Data_out;
`ifdef INTERLEAVER_BYPASS_EN
  logic bypass = 1'b0;
`endif

  wimax_interleaver dut (
    .clk       (clk),
    .rstn      (rstn),
`ifdef INTERLEAVER_BYPASS_EN
    .bypass    (bypass),
`endif
    .Valid_in  (Valid_in),
    .Data_in   (Data_in),
    .Ready_in  (Ready_in),
    .Ready_out (Ready_out),
    .Valid_out (Valid_out),
    .Data_out  (Data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [N-1:0] din;
    logic [N-1:0] dout;
  } vec_t;

  vec_t tbl [4];
  int   tests = 0;
  int   fails = 0;

  // Reference model: pending partial block, queue of expected output bits, count of full buffers.
  bit   in_blk [$];
  bit   exp_q  [$];
  int   nfull;
  int   out_cnt;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    in_blk.delete();
    exp_q.delete();
    nfull   = 0;
    out_cnt = 0;
  endfunction

  // Output position j carries input bit k = 16*(j mod 12) + floor(j/12).
  function automatic void model_complete_block();
    for (int j = 0; j < N; j++) exp_q.push_back(in_blk[16 * (j % 12) + j / 12]);
    in_blk.delete();
    nfull++;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic vin, input logic din, input logic rin,
                      output logic ob, output logic ox, output logic ix);
    bit e;
    Valid_in = vin;
    Data_in  = din;
    Ready_in = rin;
    #1;
    check("ready_out", Ready_out, (nfull < 2));
    check("valid_out", Valid_out, (nfull > 0));
    if (!Valid_out) check("data_out_idle", Data_out, 1'b0);
    ix = vin && Ready_out;
    ox = Valid_out && rin;
    ob = Data_out;
    if (ox) begin
      if (exp_q.size() == 0) begin
        check("output_without_block", ox, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("data_out", ob, e);
        out_cnt++;
        if (out_cnt == N) begin
          out_cnt = 0;
          nfull--;
        end
      end
    end
    if (ix) begin
      in_blk.push_back(din);
      if (in_blk.size() == N) model_complete_block();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    Valid_in = 1'b0;
    Data_in  = 1'b0;
    Ready_in = 1'b0;
    rstn     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    #1;
    check("reset_valid_out", Valid_out, 1'b0);
    check("reset_data_out", Data_out, 1'b0);
    check("reset_ready_out", Ready_out, 1'b1);
  endtask

  task automatic send_block(input logic [N-1:0] v, input logic rin);
    logic ob, ox, ix;
    int acc = 0;
    int cyc = 0;
    while (acc < N && cyc < 2000) begin
      step(1'b1, v[N-1-acc], rin, ob, ox, ix);
      if (ix) acc++;
      cyc++;
    end
    check("block_accepted", acc, N);
  endtask

  task automatic collect_block(output logic [N-1:0] got);
    logic ob, ox, ix;
    int cnt = 0;
    int cyc = 0;
    got = '0;
    while (cnt < N && cyc < 2000) begin
      step(1'b0, 1'b0, 1'b1, ob, ox, ix);
      if (ox) begin
        got[N-1-cnt] = ob;
        cnt++;
      end
      cyc++;
    end
    check("block_collected", cnt, N);
  endtask

  task automatic drain_all();
    logic ob, ox, ix;
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      step(1'b0, 1'b0, 1'b1, ob, ox, ix);
      cyc++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [N-1:0] v;
    logic [N-1:0] got;
    logic [N-1:0] got3 [3];
    logic         ob, ox, ix;
    logic         ready_ok;
    int           acc, cnt, cyc, drop_at, vcnt;

    tbl[0] = '{"spec_vector", 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA,
                              192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E};
    v = '0;   v[N-1-17] = 1'b1;
    got = '0; got[N-1-13] = 1'b1;
    tbl[1] = '{"single_one_k17", v, got};
    tbl[2] = '{"all_zero", '0, '0};
    tbl[3] = '{"all_one", '1, '1};

    model_reset();
    do_reset();

    // Table: fill with Ready_in=0, then drain and compare the whole block.
    for (int t = 0; t < 4; t++) begin
      send_block(tbl[t].din, 1'b0);
      check("latency_valid_after_last_bit", Valid_out, 1'b1);
      collect_block(got);
      check(tbl[t].name, got, tbl[t].dout);
    end

    // Ping-pong: three back-to-back blocks, continuous ready.
    ready_ok = 1'b1;
    cnt = 0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < N; i++) begin
        step(1'b1, tbl[0].din[N-1-i], 1'b1, ob, ox, ix);
        if (!ix) ready_ok = 1'b0;
        if (ox) begin
          got3[cnt / N][N-1-(cnt % N)] = ob;
          cnt++;
        end
      end
    end
    cyc = 0;
    while (cnt < 3 * N && cyc < 1000) begin
      step(1'b0, 1'b0, 1'b1, ob, ox, ix);
      if (ox) begin
        got3[cnt / N][N-1-(cnt % N)] = ob;
        cnt++;
      end
      cyc++;
    end
    check("pingpong_ready_held", ready_ok, 1'b1);
    check("pingpong_bit_count", cnt, 3 * N);
    for (int b = 0; b < 3; b++) check($sformatf("pingpong_copy%0d", b), got3[b], tbl[0].dout);

    // Backpressure: two blocks fill both buffers, a third stalls.
    acc = 0;
    drop_at = -1;
    for (int i = 0; i < 3 * N; i++) begin
      step(1'b1, tbl[0].din[N-1-(acc % N)], 1'b0, ob, ox, ix);
      if (ix) acc++;
      if (!Ready_out && drop_at < 0) drop_at = acc;
    end
    check("bp_accepted", acc, 2 * N);
    check("bp_ready_drop_point", drop_at, 2 * N);
    cnt = 0;
    cyc = 0;
    while (!Ready_out && cyc < 1000) begin
      step(1'b0, 1'b0, 1'b1, ob, ox, ix);
      if (ox) cnt++;
      cyc++;
    end
    check("bp_outputs_before_ready", cnt, N);
    drain_all();

    // Reset after 100 input bits: nothing may come out, then a clean block works.
    for (int i = 0; i < 100; i++) step(1'b1, tbl[0].din[N-1-i], 1'b1, ob, ox, ix);
    do_reset();
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b1, ob, ox, ix);
      if (ox) vcnt++;
    end
    check("midreset_no_output", vcnt, 0);
    send_block(tbl[0].din, 1'b0);
    collect_block(got);
    check("after_reset_block", got, tbl[0].dout);

    // Randomized valid/ready gaps checked bit-by-bit by the model.
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0, ob, ox, ix);
    drain_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
